vram_arbiter: RTL and testbench

Arbitrates the single-port frame buffer VRAM between three requesters: the VGA display fetch, a CPU pixel-write port, and a built-in screen-clear engine. The frame buffer holds 153,600 × 3-bit locations (320 × 480, RGB in bits [2:0]), and the VRAM has 1-cycle read latency.
- Display fetch has absolute priority.
- CPU writes are buffered in a small FIFO and drained into free cycles.
- The clear engine fills the whole buffer with one colour when triggered.

---
 rtl/vram_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 45 ++++
 rtl/vram_arbiter.sv | 164 ++++++++++++++++
 tb/tb_vram_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared sizes and enums for the frame-buffer VRAM arbiter.
package vram_pkg;

    localparam int ADDR_W     = 18;
    localparam int DATA_W     = 3;
    localparam int DEPTH      = 153600;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        CLEAR
    } clr_state_t;

    typedef enum logic [1:0] {
        G_NONE,
        G_DISP,
        G_CLR,
        G_CPU
    } grant_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word fall-through read data.
module sync_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 4
) (
    input  logic             clk_25MHz,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_25MHz) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetch first, then screen clear, then buffered CPU writes.
module vram_arbiter #(
    parameter int ADDR_W     = vram_pkg::ADDR_W,
    parameter int DATA_W     = vram_pkg::DATA_W,
    parameter int DEPTH      = vram_pkg::DEPTH,
    parameter int FIFO_DEPTH = vram_pkg::FIFO_DEPTH
) (
    input  logic              clk_25MHz,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    input  logic              cpu_wr_valid,
    output logic              cpu_wr_ready,
    input  logic [ADDR_W-1:0] cpu_wr_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_we,
    output logic [DATA_W-1:0] vram_wdata,
    input  logic [DATA_W-1:0] vram_rdata
);

    import vram_pkg::*;

    localparam int FW = ADDR_W + DATA_W;

    clr_state_t        state;
    clr_state_t        state_nxt;
    grant_t            grant;
    logic [ADDR_W-1:0] last_disp_addr;
    logic              last_disp_vld;
    logic              rdy_en;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] clr_color_q;
    logic              clr_last;
    logic              disp_new;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FW-1:0]     fifo_wdata;
    logic [FW-1:0]     fifo_rdata;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              vld_p0;
    logic              vld_p1;

    // rdy_en keeps ready low until the first clock after reset release.
    assign cpu_wr_ready = rdy_en && !fifo_full && (state == IDLE);
    assign fifo_push    = cpu_wr_valid && cpu_wr_ready;
    assign fifo_pop     = (grant == G_CPU);
    assign fifo_wdata   = {cpu_wr_addr, cpu_wr_data};
    assign {head_addr, head_data} = fifo_rdata;
    assign clr_busy     = (state != IDLE);
    assign clr_last     = (clr_cnt == ADDR_W'(DEPTH - 1));
    assign disp_new     = disp_req && (!last_disp_vld || (disp_addr != last_disp_addr));

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_25MHz (clk_25MHz),
        .reset     (reset),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .wdata     (fifo_wdata),
        .rdata     (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        grant = G_NONE;
        if (disp_new)           grant = G_DISP;
        else if (state == CLEAR) grant = G_CLR;
        else if (!fifo_empty)   grant = G_CPU;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr_start) state_nxt = DRAIN;
            DRAIN:   if (fifo_empty) state_nxt = CLEAR;
            CLEAR:   if ((grant == G_CLR) && clr_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            clr_cnt     <= '0;
            clr_color_q <= '0;
        end else begin
            if ((state == IDLE) && clr_start) clr_color_q <= clr_color;
            if ((state == DRAIN) && fifo_empty) clr_cnt <= '0;
            else if (grant == G_CLR)            clr_cnt <= clr_cnt + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            last_disp_vld  <= 1'b0;
            last_disp_addr <= '0;
            rdy_en         <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (!disp_req) begin
                last_disp_vld <= 1'b0;
            end else if (grant == G_DISP) begin
                last_disp_vld  <= 1'b1;
                last_disp_addr <= disp_addr;
            end
        end
    end

    // Stage p0: granted access registered onto the VRAM port.
    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            vram_addr  <= '0;
            vram_we    <= 1'b0;
            vram_wdata <= '0;
            vld_p0     <= 1'b0;
        end else begin
            vram_we <= 1'b0;
            vld_p0  <= (grant == G_DISP);
            case (grant)
                G_DISP: vram_addr <= disp_addr;
                G_CLR: begin
                    vram_addr  <= clr_cnt;
                    vram_we    <= 1'b1;
                    vram_wdata <= clr_color_q;
                end
                G_CPU: begin
                    if (head_addr < ADDR_W'(DEPTH)) begin
                        vram_addr  <= head_addr;
                        vram_we    <= 1'b1;
                        vram_wdata <= head_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage p1: VRAM samples the address; stage p2: read data captured for display.
    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            vld_p1    <= 1'b0;
            disp_data <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p1) disp_data <= vram_rdata;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomised and directed bench for vram_arbiter against a queue-based behavioural model.
module tb_vram_arbiter;

    localparam int AW = 18;
    localparam int DW = 3;
    localparam int TD = 2048;   // shortened frame buffer keeps a full clear short
    localparam int FD = 4;

    logic          clk_25MHz = 1'b0;
    logic          reset     = 1'b1;
    logic          disp_req  = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic [DW-1:0] disp_data;
    logic          cpu_wr_valid = 1'b0;
    logic          cpu_wr_ready;
    logic [AW-1:0] cpu_wr_addr = '0;
    logic [DW-1:0] cpu_wr_data = '0;
    logic          clr_start = 1'b0;
    logic [DW-1:0] clr_color = '0;
    logic          clr_busy;
    logic [AW-1:0] vram_addr;
    logic          vram_we;
    logic [DW-1:0] vram_wdata;
    logic [DW-1:0] vram_rdata = '0;

    int n_checks = 0;
    int n_pass   = 0;

    vram_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .DEPTH      (TD),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk_25MHz    (clk_25MHz),
        .reset        (reset),
        .disp_req     (disp_req),
        .disp_addr    (disp_addr),
        .disp_data    (disp_data),
        .cpu_wr_valid (cpu_wr_valid),
        .cpu_wr_ready (cpu_wr_ready),
        .cpu_wr_addr  (cpu_wr_addr),
        .cpu_wr_data  (cpu_wr_data),
        .clr_start    (clr_start),
        .clr_color    (clr_color),
        .clr_busy     (clr_busy),
        .vram_addr    (vram_addr),
        .vram_we      (vram_we),
        .vram_wdata   (vram_wdata),
        .vram_rdata   (vram_rdata)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    // VRAM: registered read, one-cycle latency.
    bit [DW-1:0] vmem [0:(1<<AW)-1];
    always @(posedge clk_25MHz) begin
        vram_rdata <= vmem[vram_addr];
        if (vram_we) vmem[vram_addr] <= vram_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { bit [AW-1:0] a; bit [DW-1:0] d; } wr_t;
    wr_t         mq[$];
    bit [DW-1:0] mmem [0:(1<<AW)-1];
    int          m_mode;            // 0 idle, 1 draining, 2 clearing
    int          pre_mode;
    bit [AW-1:0] m_cnt;
    bit [DW-1:0] m_col;
    bit          m_rdy_en, m_last_v;
    bit [AW-1:0] m_last_a;
    bit [AW-1:0] m_addr;
    bit          m_we;
    bit [DW-1:0] m_wdata, m_disp;
    bit          p1_v, p2_v;
    bit [DW-1:0] p1_d, p2_d;
    bit          acc, hit, was_empty;
    wr_t         w;

    always @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_mode = 0; m_cnt = '0; m_col = '0; m_rdy_en = 0; m_last_v = 0; m_last_a = '0;
            m_addr = '0; m_we = 0; m_wdata = '0; m_disp = '0;
            p1_v = 0; p2_v = 0; p1_d = '0; p2_d = '0;
        end else begin
            pre_mode  = m_mode;
            was_empty = (mq.size() == 0);
            acc = cpu_wr_valid && m_rdy_en && (mq.size() < FD) && (m_mode == 0);
            hit = disp_req && (!m_last_v || (disp_addr != m_last_a));
            if (p2_v) m_disp = p2_d;
            p2_v = p1_v; p2_d = p1_d;
            p1_v = hit;  p1_d = mmem[disp_addr];
            m_we = 0;
            if (hit) begin
                m_addr = disp_addr;
            end else if (pre_mode == 2) begin
                m_addr = m_cnt; m_we = 1; m_wdata = m_col; mmem[m_cnt] = m_col;
                if (int'(m_cnt) == TD - 1) m_mode = 0;
                else m_cnt = m_cnt + 1;
            end else if (!was_empty) begin
                w = mq.pop_front();
                if (int'(w.a) < TD) begin
                    m_addr = w.a; m_we = 1; m_wdata = w.d; mmem[w.a] = w.d;
                end
            end
            if (!disp_req) m_last_v = 0;
            else if (hit) begin m_last_v = 1; m_last_a = disp_addr; end
            if (pre_mode == 0 && clr_start) begin m_col = clr_color; m_mode = 1; end
            if (pre_mode == 1 && was_empty) begin m_mode = 2; m_cnt = '0; end
            if (acc) mq.push_back('{a: cpu_wr_addr, d: cpu_wr_data});
            m_rdy_en = 1;
        end
    end

    always @(negedge clk_25MHz) begin
        if (!reset) begin
            chk("vram_addr",    32'(vram_addr),    32'(m_addr));
            chk("vram_we",      32'(vram_we),      32'(m_we));
            chk("vram_wdata",   32'(vram_wdata),   32'(m_wdata));
            chk("disp_data",    32'(disp_data),    32'(m_disp));
            chk("cpu_wr_ready", 32'(cpu_wr_ready), 32'(m_rdy_en && (mq.size() < FD) && (m_mode == 0)));
            chk("clr_busy",     32'(clr_busy),     32'(m_mode != 0));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk_25MHz);
        #1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_addr"},  32'(vram_addr),    0);
        chk({tag, "_we"},    32'(vram_we),      0);
        chk({tag, "_wdata"}, 32'(vram_wdata),   0);
        chk({tag, "_disp"},  32'(disp_data),    0);
        chk({tag, "_ready"}, 32'(cpu_wr_ready), 0);
        chk({tag, "_busy"},  32'(clr_busy),     0);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        while (clr_busy && n < limit) begin tick(); n++; end
        chk({tag, "_clear_done"}, 32'(n < limit), 1);
    endtask

    task automatic count_mem(input logic [DW-1:0] col, output int bad);
        bad = 0;
        for (int i = 0; i < TD; i++) if (vmem[i] != col) bad++;
    endtask

    initial begin
        int sent, drops, nwe, bad, lim, col_wr;
        bit r, v;
        logic [AW-1:0] wq[$];

        repeat (3) @(posedge clk_25MHz);
        #1;
        chk_outputs_zero("rst");
        reset = 1'b0;
        #1 chk("ready_before_clk", 32'(cpu_wr_ready), 0);
        tick();
        chk("ready_after_clk", 32'(cpu_wr_ready), 1);

        // single CPU write, then read it back through the display path
        cpu_wr_valid = 1; cpu_wr_addr = 18'h00010; cpu_wr_data = 3'b101;
        tick();
        cpu_wr_valid = 0;
        chk("t1_we_early", 32'(vram_we), 0);
        tick();
        chk("t1_we", 32'(vram_we), 1);
        chk("t1_addr", 32'(vram_addr), 32'h10);
        chk("t1_wdata", 32'(vram_wdata), 5);
        tick();
        disp_req = 1; disp_addr = 18'h00010;
        tick();
        chk("t1_rd_addr", 32'(vram_addr), 32'h10);
        tick();
        disp_req = 0;
        chk("t1_disp_early", 32'(disp_data), 0);
        tick();
        chk("t1_disp", 32'(disp_data), 5);

        // display pairs 0,0,1,1,... with 8 back-to-back CPU writes
        sent = 0; drops = 0;
        for (int c = 0; c < 40; c++) begin
            disp_req = 1; disp_addr = 18'(100 + c / 2);
            v = (sent < 8);
            cpu_wr_valid = v; cpu_wr_addr = 18'(200 + sent); cpu_wr_data = 3'(sent + 1);
            r = cpu_wr_ready;
            if (!r) drops++;
            tick();
            if (v && r) sent++;
            if (vram_we) wq.push_back(vram_addr);
        end
        cpu_wr_valid = 0; disp_req = 0;
        chk("t2_sent", 32'(sent), 8);
        chk("t2_ready_dropped", 32'(drops > 0), 1);
        chk("t2_nwrites", 32'(wq.size()), 8);
        for (int i = 0; i < 8; i++) chk("t2_order", 32'(wq[i]), 32'(200 + i));
        repeat (4) tick();

        // display changing every cycle starves a pending write
        disp_req = 1; disp_addr = 18'd300;
        tick();
        nwe = 0;
        for (int c = 0; c < 10; c++) begin
            disp_addr = disp_addr + 18'd1;
            cpu_wr_valid = (c == 0); cpu_wr_addr = 18'd400; cpu_wr_data = 3'd3;
            tick();
            if (vram_we) nwe++;
        end
        cpu_wr_valid = 0;
        chk("t3_starved", 32'(nwe), 0);
        disp_req = 0;
        tick();
        chk("t3_we", 32'(vram_we), 1);
        chk("t3_addr", 32'(vram_addr), 400);
        chk("t3_wdata", 32'(vram_wdata), 3);
        repeat (3) tick();

        // clear with three writes still queued; second clr_start ignored
        disp_req = 1;
        for (int i = 0; i < 3; i++) begin
            disp_addr = 18'(700 + i);
            cpu_wr_valid = 1; cpu_wr_addr = 18'(500 + i); cpu_wr_data = 3'd7;
            tick();
        end
        cpu_wr_valid = 0; disp_addr = 18'd703;
        tick();
        disp_req = 0; clr_start = 1; clr_color = 3'b010;
        wq.delete(); bad = 1; col_wr = 0;
        tick();
        clr_start = 0;
        if (vram_we) wq.push_back(vram_addr);
        lim = 0;
        while (clr_busy && lim < 4 * TD + 100) begin
            disp_req = 1'($urandom_range(0, 1));
            disp_addr = 18'($urandom_range(0, TD - 1));
            clr_start = (lim == 1000); clr_color = 3'd7;
            tick();
            lim++;
            if (vram_we) begin
                wq.push_back(vram_addr);
                if (vram_wdata == 3'b010) col_wr++;
                if (int'(vram_addr) == TD - 1) bad = 32'(clr_busy);
            end
        end
        clr_start = 0; disp_req = 0;
        chk("t4_clear_done", 32'(lim < 4 * TD + 100), 1);
        chk("t4_first_cpu0", 32'(wq[0]), 500);
        chk("t4_first_cpu1", 32'(wq[1]), 501);
        chk("t4_first_cpu2", 32'(wq[2]), 502);
        chk("t4_nwrites", 32'(wq.size()), 32'(TD + 3));
        chk("t4_clear_writes", 32'(col_wr), 32'(TD));
        chk("t4_busy_at_last", 32'(bad), 0);
        repeat (3) tick();
        count_mem(3'b010, bad);
        chk("t4_mem_filled", 32'(bad), 0);

        // reset in the middle of a clear
        clr_start = 1; clr_color = 3'd5;
        tick();
        clr_start = 0;
        lim = 0;
        while (!(vram_we && vram_addr == 18'd1000) && lim < 3000) begin tick(); lim++; end
        chk("t5_reach_1000", 32'(lim < 3000), 1);
        reset = 1;
        #1 chk_outputs_zero("t5_async");
        tick(); tick();
        reset = 0;
        #1 chk("t5_busy_after", 32'(clr_busy), 0);
        tick();
        chk("t5_ready_after", 32'(cpu_wr_ready), 1);
        clr_start = 1; clr_color = 3'd6;
        tick();
        clr_start = 0;
        lim = 0;
        while (!vram_we && lim < 10) begin tick(); lim++; end
        chk("t5_first_addr", 32'(vram_addr), 0);
        chk("t5_first_data", 32'(vram_wdata), 6);
        wait_idle("t5", 2 * TD);
        repeat (3) tick();
        count_mem(3'd6, bad);
        chk("t5_mem_filled", 32'(bad), 0);

        // out-of-range writes are consumed but never reach VRAM
        cpu_wr_valid = 1; cpu_wr_addr = 18'(TD); cpu_wr_data = 3'd7;
        tick();
        cpu_wr_addr = 18'd153600;
        tick();
        cpu_wr_valid = 0;
        nwe = 0;
        for (int c = 0; c < 4; c++) begin tick(); if (vram_we) nwe++; end
        chk("t6_no_write", 32'(nwe), 0);
        chk("t6_ready", 32'(cpu_wr_ready), 1);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            disp_req = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 1) == 0) disp_addr = 18'($urandom_range(0, TD - 1));
            cpu_wr_valid = ($urandom_range(0, 9) < 4);
            cpu_wr_addr  = ($urandom_range(0, 15) == 0) ? 18'(TD + $urandom_range(0, 100))
                                                         : 18'($urandom_range(0, TD - 1));
            cpu_wr_data  = 3'($urandom);
            clr_start    = ($urandom_range(0, 1499) == 0);
            clr_color    = 3'($urandom);
            tick();
        end
        disp_req = 0; cpu_wr_valid = 0; clr_start = 0;
        wait_idle("t7", 2 * TD + 100);
        repeat (8) tick();
        bad = 0;
        for (int i = 0; i < TD; i++) if (vmem[i] != mmem[i]) bad++;
        chk("t7_mem_match", 32'(bad), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
